// File: rtl/cpu_pkg.sv
// Shared types for the unified-memory port arbiter: FSM states, port owners,
// access size codes and the size-to-beat-count mapping.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } owner_e;

  // d_size encodings; any code with bit 1 set is a word access
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  // Instruction fetches are always full words
  localparam logic [2:0] FETCH_BEATS = 3'd4;

  // Latency counter width, enough for MEM_LAT up to 8 (counts 0..7)
  localparam int LAT_W = 3;

  function automatic logic [2:0] size_to_beats(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      default:   return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_beat_seq.sv
// Byte-beat sequencer: walks base+k addresses, holds each beat for MEM_LAT
// cycles, shifts read bytes in MSB-first and picks the big-endian write byte.
module mem_beat_seq
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              active_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [31:0]       wdata_i,
  input  logic [2:0]        beats_i,
  input  logic [7:0]        mem_rdata_i,
  output logic              last_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [7:0]        wbyte_o,
  output logic [31:0]       word_o
);

  logic [ADDR_W-1:0] base_q, base_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        nbeats_q, nbeats_d;
  logic [1:0]        beat_q, beat_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       shift_q, shift_d;
  logic              beat_end;
  logic [1:0]        byte_idx;

  assign beat_end = active_i && (lat_q == LAT_W'(MEM_LAT - 1));
  assign last_o   = beat_end && ({1'b0, beat_q} == (nbeats_q - 3'd1));
  assign addr_o   = base_q + ADDR_W'(beat_q);
  // Includes the byte arriving on this cycle so the word is complete on the last beat
  assign word_o   = {shift_q[23:0], mem_rdata_i};
  // Beat k of an N-beat store carries byte (N-1-k) of the right-justified data
  assign byte_idx = 2'(nbeats_q - 3'd1) - beat_q;

  // Select the store byte for the current beat
  always_comb begin
    wbyte_o = wdata_q[7:0];
    case (byte_idx)
      2'd0: wbyte_o = wdata_q[7:0];
      2'd1: wbyte_o = wdata_q[15:8];
      2'd2: wbyte_o = wdata_q[23:16];
      2'd3: wbyte_o = wdata_q[31:24];
      default: wbyte_o = wdata_q[7:0];
    endcase
  end

  // Load operands at grant, then advance latency and beat counters
  always_comb begin
    base_d   = base_q;
    wdata_d  = wdata_q;
    nbeats_d = nbeats_q;
    beat_d   = beat_q;
    lat_d    = lat_q;
    shift_d  = shift_q;
    if (start_i) begin
      base_d   = base_i;
      wdata_d  = wdata_i;
      nbeats_d = beats_i;
      beat_d   = 2'd0;
      lat_d    = '0;
      shift_d  = 32'h0;
    end else if (beat_end) begin
      lat_d   = '0;
      beat_d  = beat_q + 2'd1;
      shift_d = {shift_q[23:0], mem_rdata_i};
    end else if (active_i) begin
      lat_d = lat_q + 1'b1;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q   <= '0;
      wdata_q  <= 32'h0;
      nbeats_q <= 3'd0;
      beat_q   <= 2'd0;
      lat_q    <= '0;
      shift_q  <= 32'h0;
    end else begin
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      nbeats_q <= nbeats_d;
      beat_q   <= beat_d;
      lat_q    <= lat_d;
      shift_q  <= shift_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one byte-wide memory port,
// alternating ownership under contention and pulsing done per transaction.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int MEM_LAT = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              pc_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_owner_q, last_owner_d;
  logic              we_q, we_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;
  logic              grant;
  owner_e            grant_owner;
  logic [ADDR_W-1:0] grant_addr;
  logic [2:0]        grant_beats;
  logic              beat_active;
  logic              seq_last;
  logic [ADDR_W-1:0] seq_addr;
  logic [7:0]        seq_wbyte;
  logic [31:0]       seq_word;

  // Grant in IDLE; under contention the port that did not go last wins
  always_comb begin
    grant       = 1'b0;
    grant_owner = OWN_FETCH;
    if (state_q == ST_IDLE) begin
      if (if_req && d_req) begin
        grant       = 1'b1;
        grant_owner = (last_owner_q == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      end else if (d_req) begin
        grant       = 1'b1;
        grant_owner = OWN_DATA;
      end else if (if_req) begin
        grant       = 1'b1;
        grant_owner = OWN_FETCH;
      end
    end
  end

  assign grant_addr  = (grant_owner == OWN_DATA) ? d_addr : if_addr;
  assign grant_beats = (grant_owner == OWN_DATA) ? size_to_beats(d_size) : FETCH_BEATS;
  assign beat_active = (state_q == ST_BEAT);

  mem_beat_seq #(
    .MEM_LAT (MEM_LAT),
    .ADDR_W  (ADDR_W)
  ) u_seq (
    .clk         (clk),
    .reset       (reset),
    .start_i     (grant),
    .active_i    (beat_active),
    .base_i      (grant_addr),
    .wdata_i     (d_wdata),
    .beats_i     (grant_beats),
    .mem_rdata_i (mem_rdata),
    .last_o      (seq_last),
    .addr_o      (seq_addr),
    .wbyte_o     (seq_wbyte),
    .word_o      (seq_word)
  );

  // FSM next state; read data lands on the edge into DONE so it is valid with done
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    we_d         = we_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_BEAT;
          owner_d = grant_owner;
          we_d    = (grant_owner == OWN_DATA) && d_we;
        end
      end
      ST_BEAT: begin
        if (seq_last) begin
          state_d      = ST_DONE;
          last_owner_d = owner_q;
          if (owner_q == OWN_FETCH) begin
            if_rdata_d = seq_word;
          end else if (!we_q) begin
            d_rdata_d = seq_word;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and owner registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_FETCH;
      last_owner_q <= OWN_FETCH;
      we_q         <= 1'b0;
      if_rdata_q   <= 32'h0;
      d_rdata_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      we_q         <= we_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = (state_q == ST_DONE) && (owner_q == OWN_FETCH);
  assign d_done    = (state_q == ST_DONE) && (owner_q == OWN_DATA);
  assign pc_stall  = if_req & ~if_done;
  assign mem_en    = beat_active;
  assign mem_we    = beat_active & we_q;
  assign mem_addr  = beat_active ? seq_addr : '0;
  assign mem_wdata = (beat_active && we_q) ? seq_wbyte : 8'h00;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (MEM_LAT 1 and 3) against a
// transaction-level reference model with its own byte memory image.
module tb_mem_port_arbiter;

  int tests = 0;
  int fails = 0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req [2];
  logic [31:0] if_addr [2];
  logic [31:0] if_rdata [2];
  logic        if_done [2];
  logic        d_req [2];
  logic        d_we [2];
  logic [1:0]  d_size [2];
  logic [31:0] d_addr [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic        d_done [2];
  logic        pc_stall [2];
  logic        mem_en [2];
  logic        mem_we [2];
  logic [31:0] mem_addr [2];
  logic [7:0]  mem_wdata [2];
  logic [7:0]  mem_rdata [2];

  logic [7:0]  dev_mem [2][256];
  logic [7:0]  ref_mem [2][256];
  logic        sync_req;

  // Reference model state
  logic [31:0] exp_if [2];
  logic [31:0] exp_d [2];
  bit          exp_last_data [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    mem_port_arbiter #(
      .MEM_LAT ((gi == 0) ? 1 : 3),
      .ADDR_W  (32)
    ) u_dut (
      .clk       (clk),
      .reset     (rst_n),
      .if_req    (if_req[gi]),
      .if_addr   (if_addr[gi]),
      .if_rdata  (if_rdata[gi]),
      .if_done   (if_done[gi]),
      .d_req     (d_req[gi]),
      .d_we      (d_we[gi]),
      .d_size    (d_size[gi]),
      .d_addr    (d_addr[gi]),
      .d_wdata   (d_wdata[gi]),
      .d_rdata   (d_rdata[gi]),
      .d_done    (d_done[gi]),
      .pc_stall  (pc_stall[gi]),
      .mem_en    (mem_en[gi]),
      .mem_we    (mem_we[gi]),
      .mem_addr  (mem_addr[gi]),
      .mem_wdata (mem_wdata[gi]),
      .mem_rdata (mem_rdata[gi])
    );
    assign mem_rdata[gi] = dev_mem[gi][mem_addr[gi][7:0]];
  end

  // Byte memory device: preload copy or byte writes from the DUT
  always @(posedge clk) begin
    if (sync_req) begin
      for (int u = 0; u < 2; u++)
        for (int j = 0; j < 256; j++)
          dev_mem[u][j] <= ref_mem[u][j];
    end else begin
      for (int u = 0; u < 2; u++)
        if (mem_en[u] === 1'b1 && mem_we[u] === 1'b1)
          dev_mem[u][mem_addr[u][7:0]] <= mem_wdata[u];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat_of(input int u);
    return (u == 0) ? 1 : 3;
  endfunction

  function automatic int beats_of(input bit fetch, input logic [1:0] size);
    if (fetch) return 4;
    if (size == 2'b00) return 1;
    if (size == 2'b01) return 2;
    return 4;
  endfunction

  // Big-endian read of n bytes from the model image, right-justified
  function automatic logic [31:0] ref_read(input int u, input logic [31:0] addr, input int n);
    logic [31:0] w;
    logic [31:0] a;
    w = 32'h0;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      w = {w[23:0], ref_mem[u][a[7:0]]};
    end
    return w;
  endfunction

  task automatic ref_store(input int u, input logic [31:0] addr, input logic [31:0] wd, input int n);
    logic [31:0] a;
    for (int k = 0; k < n; k++) begin
      a = addr + 32'(k);
      ref_mem[u][a[7:0]] = wd[(n-1-k)*8 +: 8];
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      exp_if[u] = 32'h0;
      exp_d[u] = 32'h0;
      exp_last_data[u] = 1'b0;
    end
  endtask

  // One transaction on a single port: drive, follow every cycle, check, drop req after done
  task automatic run_txn(input int u, input bit fetch, input bit we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd, input string tag);
    int n, lat, k;
    bit got;
    logic [31:0] exp_word, ea;
    logic [7:0] eb;
    logic done_now, done_other;
    n = beats_of(fetch, size);
    lat = lat_of(u);
    exp_word = ref_read(u, addr, n);
    if (fetch) begin
      if_req[u] = 1'b1; if_addr[u] = addr;
    end else begin
      d_req[u] = 1'b1; d_we[u] = we; d_size[u] = size; d_addr[u] = addr; d_wdata[u] = wd;
    end
    #1;
    if (fetch) begin
      tests++;
      if (pc_stall[u] !== 1'b1) begin fails++; $display("FAIL %s pc_stall c0: got %b want 1", tag, pc_stall[u]); end
    end
    got = 1'b0;
    for (int c = 1; c <= n*lat + 4 && !got; c++) begin
      @(negedge clk);
      tests++;
      if (mem_en[u] !== (c <= n*lat)) begin
        fails++; $display("FAIL %s mem_en c%0d: got %b want %b", tag, c, mem_en[u], (c <= n*lat));
      end
      if (c <= n*lat) begin
        k = (c - 1) / lat;
        ea = addr + 32'(k);
        tests++;
        if (mem_addr[u] !== ea) begin fails++; $display("FAIL %s mem_addr c%0d: got %h want %h", tag, c, mem_addr[u], ea); end
        tests++;
        if (mem_we[u] !== (!fetch && we)) begin fails++; $display("FAIL %s mem_we c%0d: got %b want %b", tag, c, mem_we[u], (!fetch && we)); end
        if (!fetch && we) begin
          eb = wd[(n-1-k)*8 +: 8];
          tests++;
          if (mem_wdata[u] !== eb) begin fails++; $display("FAIL %s mem_wdata c%0d: got %h want %h", tag, c, mem_wdata[u], eb); end
        end
      end
      done_now = fetch ? if_done[u] : d_done[u];
      done_other = fetch ? d_done[u] : if_done[u];
      tests++;
      if (done_now !== (c == n*lat + 1)) begin fails++; $display("FAIL %s done c%0d: got %b want %b", tag, c, done_now, (c == n*lat + 1)); end
      tests++;
      if (done_other !== 1'b0) begin fails++; $display("FAIL %s other_done c%0d: got %b want 0", tag, c, done_other); end
      if (fetch) begin
        tests++;
        if (pc_stall[u] !== (c <= n*lat)) begin fails++; $display("FAIL %s pc_stall c%0d: got %b want %b", tag, c, pc_stall[u], (c <= n*lat)); end
      end
      if (done_now === 1'b1) begin
        got = 1'b1;
        if (fetch) exp_if[u] = exp_word;
        else if (!we) exp_d[u] = exp_word;
        else ref_store(u, addr, wd, n);
        exp_last_data[u] = !fetch;
        tests++;
        if (if_rdata[u] !== exp_if[u]) begin fails++; $display("FAIL %s if_rdata: got %h want %h", tag, if_rdata[u], exp_if[u]); end
        tests++;
        if (d_rdata[u] !== exp_d[u]) begin fails++; $display("FAIL %s d_rdata: got %h want %h", tag, d_rdata[u], exp_d[u]); end
        if_req[u] = 1'b0; d_req[u] = 1'b0;
      end else begin
        // The requester changes its operands mid-flight; the captured values must hold
        if_addr[u] = $urandom; d_addr[u] = $urandom; d_wdata[u] = $urandom;
        d_size[u] = 2'($urandom); d_we[u] = 1'($urandom);
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL %s timeout: got no done want done at cycle %0d", tag, n*lat + 1);
      if_req[u] = 1'b0; d_req[u] = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (mem_en[u] !== 1'b0 || if_done[u] !== 1'b0 || d_done[u] !== 1'b0) begin
      fails++; $display("FAIL %s idle_after: got en=%b ifd=%b dd=%b want 000", tag, mem_en[u], if_done[u], d_done[u]);
    end
    $display("[TB] txn %s u%0d fetch=%0d we=%0d n=%0d addr=%h", tag, u, fetch, we, n, addr);
  endtask

  task automatic test_reset();
    for (int u = 0; u < 2; u++) begin
      tests++;
      if (if_rdata[u] !== 32'h0 || d_rdata[u] !== 32'h0) begin
        fails++; $display("FAIL reset rdata u%0d: got %h/%h want 0/0", u, if_rdata[u], d_rdata[u]);
      end
      tests++;
      if (if_done[u] !== 1'b0 || d_done[u] !== 1'b0 || pc_stall[u] !== 1'b0) begin
        fails++; $display("FAIL reset flags u%0d: got %b%b%b want 000", u, if_done[u], d_done[u], pc_stall[u]);
      end
      tests++;
      if (mem_en[u] !== 1'b0 || mem_we[u] !== 1'b0 || mem_addr[u] !== 32'h0 || mem_wdata[u] !== 8'h0) begin
        fails++; $display("FAIL reset mem u%0d: got en=%b we=%b a=%h wd=%h want zeros", u, mem_en[u], mem_we[u], mem_addr[u], mem_wdata[u]);
      end
    end
    $display("[TB] txn reset checked");
  endtask

  // Both requests held from reset release: grants DATA, FETCH, DATA at 6-cycle spacing
  task automatic test_arbitration();
    logic [31:0] wf, wdw;
    wf = ref_read(0, 32'h40, 4);
    wdw = ref_read(0, 32'h80, 4);
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_size[0] = 2'b10; d_addr[0] = 32'h80; d_wdata[0] = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      tests++;
      if (d_done[0] !== (c == 5 || c == 17)) begin fails++; $display("FAIL arb d_done c%0d: got %b want %b", c, d_done[0], (c == 5 || c == 17)); end
      tests++;
      if (if_done[0] !== (c == 11)) begin fails++; $display("FAIL arb if_done c%0d: got %b want %b", c, if_done[0], (c == 11)); end
      if (c == 5 || c == 17) begin
        tests++;
        if (d_rdata[0] !== wdw) begin fails++; $display("FAIL arb d_rdata c%0d: got %h want %h", c, d_rdata[0], wdw); end
      end
      if (c == 11) begin
        tests++;
        if (if_rdata[0] !== wf) begin fails++; $display("FAIL arb if_rdata: got %h want %h", if_rdata[0], wf); end
      end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    exp_if[0] = wf; exp_d[0] = wdw; exp_last_data[0] = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_en[0] !== 1'b0) begin fails++; $display("FAIL arb idle mem_en: got %b want 0", mem_en[0]); end
    $display("[TB] txn arbitration D,F,D");
  endtask

  task automatic test_fetch();
    run_txn(0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, "fetch_word");
    tests++;
    if (if_rdata[0] !== 32'h2401002C) begin fails++; $display("FAIL fetch_word value: got %h want 2401002c", if_rdata[0]); end
  endtask

  task automatic test_byte_store();
    logic [31:0] old_d;
    old_d = d_rdata[0];
    run_txn(0, 1'b0, 1'b1, 2'b00, 32'h21, 32'hAABBCC01, "byte_store");
    tests++;
    if (dev_mem[0][8'h21] !== 8'h01) begin fails++; $display("FAIL byte_store mem: got %h want 01", dev_mem[0][8'h21]); end
    tests++;
    if (d_rdata[0] !== old_d) begin fails++; $display("FAIL byte_store d_rdata: got %h want %h", d_rdata[0], old_d); end
  endtask

  task automatic test_half_load();
    run_txn(0, 1'b0, 1'b0, 2'b01, 32'h50, 32'h0, "half_load");
    tests++;
    if (d_rdata[0] !== 32'h00001234) begin fails++; $display("FAIL half_load value: got %h want 00001234", d_rdata[0]); end
  endtask

  task automatic test_wrap_load();
    run_txn(1, 1'b0, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0, "wrap_load_lat3");
  endtask

  // Reset during beat 2 of a fetch: bus drops at once, no done, held req restarts
  task automatic test_reset_mid();
    if_req[0] = 1'b1; if_addr[0] = 32'h0;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_en[0] !== 1'b1 || mem_addr[0] !== 32'h2) begin
      fails++; $display("FAIL reset_mid beat2: got en=%b a=%h want 1/00000002", mem_en[0], mem_addr[0]);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    tests++;
    if (mem_en[0] !== 1'b0 || if_done[0] !== 1'b0) begin
      fails++; $display("FAIL reset_mid abort: got en=%b done=%b want 0/0", mem_en[0], if_done[0]);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if (if_done[0] !== 1'b0 || if_rdata[0] !== 32'h0) begin
        fails++; $display("FAIL reset_mid held: got done=%b rdata=%h want 0/0", if_done[0], if_rdata[0]);
      end
    end
    rst_n = 1'b1;
    run_txn(0, 1'b1, 1'b0, 2'b10, 32'h0, 32'h0, "reset_mid_restart");
  endtask

  // Fetch and data requested together; each requester drops after its own done
  task automatic test_contention(input int u, input int rounds);
    logic [31:0] fa, da, wd, wf, wl;
    logic [1:0] sz;
    bit we, first_data;
    int lat, nd, n1, n2, c1, c2, cf, cd;
    lat = lat_of(u);
    for (int r = 0; r < rounds; r++) begin
      fa = {24'($urandom), 8'($urandom_range(0, 112))};
      da = {24'($urandom), 8'($urandom_range(128, 240))};
      wd = $urandom; sz = 2'($urandom); we = 1'($urandom);
      nd = beats_of(1'b0, sz);
      first_data = !exp_last_data[u];
      n1 = first_data ? nd : 4;
      n2 = first_data ? 4 : nd;
      c1 = n1*lat + 1;
      c2 = c1 + 1 + n2*lat + 1;
      cd = first_data ? c1 : c2;
      cf = first_data ? c2 : c1;
      wf = ref_read(u, fa, 4);
      wl = ref_read(u, da, nd);
      if_req[u] = 1'b1; if_addr[u] = fa;
      d_req[u] = 1'b1; d_we[u] = we; d_size[u] = sz; d_addr[u] = da; d_wdata[u] = wd;
      for (int c = 1; c <= c2; c++) begin
        @(negedge clk);
        tests++;
        if (if_done[u] !== (c == cf)) begin fails++; $display("FAIL contend r%0d if_done c%0d: got %b want %b", r, c, if_done[u], (c == cf)); end
        tests++;
        if (d_done[u] !== (c == cd)) begin fails++; $display("FAIL contend r%0d d_done c%0d: got %b want %b", r, c, d_done[u], (c == cd)); end
        if (c == cf) begin
          exp_if[u] = wf;
          if_req[u] = 1'b0;
          tests++;
          if (if_rdata[u] !== wf) begin fails++; $display("FAIL contend r%0d if_rdata: got %h want %h", r, if_rdata[u], wf); end
        end
        if (c == cd) begin
          if (we) ref_store(u, da, wd, nd); else exp_d[u] = wl;
          d_req[u] = 1'b0;
          tests++;
          if (d_rdata[u] !== exp_d[u]) begin fails++; $display("FAIL contend r%0d d_rdata: got %h want %h", r, d_rdata[u], exp_d[u]); end
        end
      end
      exp_last_data[u] = !first_data;
      @(negedge clk);
      $display("[TB] txn contend u%0d r%0d first=%s we=%0d nd=%0d", u, r, first_data ? "DATA" : "FETCH", we, nd);
    end
  endtask

  task automatic test_random(input int u, input int count);
    int kind;
    for (int i = 0; i < count; i++) begin
      kind = $urandom_range(0, 2);
      run_txn(u, kind == 0, kind == 2, 2'($urandom), $urandom, $urandom, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sync_req = 1'b1;
    for (int u = 0; u < 2; u++) begin
      if_req[u] = 1'b0; if_addr[u] = 32'h0;
      d_req[u] = 1'b0; d_we[u] = 1'b0; d_size[u] = 2'b00; d_addr[u] = 32'h0; d_wdata[u] = 32'h0;
      for (int j = 0; j < 256; j++) ref_mem[u][j] = 8'($urandom);
    end
    ref_mem[0][0] = 8'h24; ref_mem[0][1] = 8'h01; ref_mem[0][2] = 8'h00; ref_mem[0][3] = 8'h2C;
    ref_mem[0][8'h50] = 8'h12; ref_mem[0][8'h51] = 8'h34;
    model_reset();
    repeat (2) @(negedge clk);
    sync_req = 1'b0;
    test_reset();
    test_arbitration();
    test_fetch();
    test_byte_store();
    test_half_load();
    test_wrap_load();
    test_reset_mid();
    test_contention(0, 4);
    test_contention(1, 4);
    test_random(0, 20);
    test_random(1, 20);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
